stream_demux2: RTL and testbench
================================

# stream_demux2

1:2 stream demultiplexer with per-channel buffering. It steers each accepted input beat to channel A (`sel_i`=0) or channel B (`sel_i`=1) and holds beats in an independent FIFO per channel until the consumer takes them. It is the receiving-end counterpart of the 2:1 byte mux: it fans a shared stream back out to two consumers. A stall on one channel never blocks traffic to the other.

## Interface
- `DATA_W`, 8, beat width in bits
- `DEPTH`, 2, entries per channel FIFO; power of two, ≥2
- `CNT_W`, 8, width of the per-channel delivered-beat counters
- `clk`  input  1  rising-edge clock
- `reset_n`  input  1  synchronous, active-low reset
- `in_valid_i`  input  1  input beat valid
- `in_ready_o`  output  1  input beat accepted this cycle if high with `in_valid_i`
- `in_data_i`  input  DATA_W  input beat
- `sel_i`  input  1  destination qualifier for the current input beat: 0 = A, 1 = B
- `a_valid_o` / `b_valid_o`  output  1  channel head valid
- `a_ready_i` / `b_ready_i`  input  1  channel consumer ready
- `a_data_o` / `b_data_o`  output  DATA_W  channel head data
- `a_count_o` / `b_count_o`  output  CNT_W  beats delivered on the channel, modulo 2^CNT_W

## Operation
- `in_ready_o` = `reset_n` && !full(channel selected by `sel_i`).
  - Combinational from `sel_i` and the registered full flags only.
  - Never depends on `a_ready_i` or `b_ready_i`. A full FIFO does not accept a push, even if it pops in the same cycle.
- Push: on `in_valid_i && in_ready_o`, `in_data_i` is written at the selected FIFO's write pointer, and that FIFO's occupancy increments.
- Pop: on `x_valid_o && x_ready_i`, the read pointer advances and occupancy decrements. `x_count_o` increments in the same edge.
- Push and pop on the same channel in the same cycle: occupancy is unchanged and FIFO order is preserved.
- `x_valid_o` = occupancy ≠ 0. `x_data_o` = entry at the read pointer.
  - `x_data_o` is stable while `x_valid_o && !x_ready_i`.
  - `x_data_o` is don't-care when `x_valid_o` is low, except after reset.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits. Full: occupancy == DEPTH. Empty: occupancy == 0.
- Counters wrap from 2^CNT_W−1 to 0 with no flag.
- `sel_i` is sampled only on an accepted beat. `sel_i` toggling while `in_valid_i` is low has no effect.
- `in_valid_i` may deassert without a handshake. The block makes no stability demand on the input side.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - Both FIFOs emptied; all pointers and occupancies set to 0.
  - `a_valid_o`=`b_valid_o`=0, `a_data_o`=`b_data_o`=0, counters=0.
  - `in_ready_o`=0 for as long as `reset_n` is low.
- Reset mid-operation discards all buffered beats. No beat is delivered after reset that was accepted before it.
- First cycle after `reset_n` rises: `in_ready_o`=1 for either `sel_i`.
- Latency: a beat accepted at edge N is presented with `x_valid_o`=1 in the cycle after edge N.
- Throughput: one beat per cycle per channel sustained when the consumer holds ready high. DEPTH ≥ 2 means the input is never throttled in this case.
- Counter update: `x_count_o` reflects a pop in the cycle after the handshake edge.

## Structure
- Package `stream_demux_pkg` holds:
  - `typedef enum logic {CH_A = 1'b0, CH_B = 1'b1} ch_e`
  - default localparams for `DATA_W`, `DEPTH` and `CNT_W`
- Sub-module `stream_fifo #(DATA_W, DEPTH)`: single-clock synchronous FIFO.
  - Ports: `push_i`, `data_i`, `full_o`, `pop_i`, `valid_o`, `data_o`, with the same reset semantics as the top level.
  - Instantiated twice.
- The top level contains the steering logic, the ready mux and the two counters.

## Test plan
- Reset mid-stream:
  - Stimulus: fill A with 0x11, 0x22, hold `reset_n`=0 for 2 cycles, then release.
  - Required: `in_ready_o`=0 during reset; after release, `a_valid_o`=0, both counts 0, `a_data_o`=0; 0x11 is never delivered.
- Basic steering:
  - Stimulus: `a_ready_i`=`b_ready_i`=1; send 0x11 (sel 0), 0xB2 (sel 1), 0x33 (sel 0) on consecutive cycles.
  - Required: A delivers 0x11 then 0x33; B delivers 0xB2; each beat appears 1 cycle after acceptance; final `a_count_o`=2, `b_count_o`=1.
- Backpressure isolation:
  - Stimulus: `a_ready_i`=0; send 0x01, 0x02, 0x03 with sel 0.
  - Required: 0x01 and 0x02 accepted; `in_ready_o`=0 for 0x03.
  - Stimulus: switch `sel_i`=1 with data 0xB0.
  - Required: `in_ready_o`=1 immediately; B delivers 0xB0 while A remains stalled with head 0x01.
- Full no-bypass:
  - Stimulus: A full; assert `a_ready_i`=1 and offer 0x03 with sel 0 in the same cycle.
  - Required: 0x03 is not accepted that cycle; it is accepted the next cycle; A order is 0x01, 0x02, 0x03.
- Simultaneous push/pop:
  - Stimulus: A holds 0x40; push 0x41 while popping.
  - Required: occupancy stays 1; next head is 0x41.
- Counter wrap:
  - Stimulus: 256 beats to B with `b_ready_i`=1 (`CNT_W`=8).
  - Required: `b_count_o` reads 0xFF after 255 beats and 0x00 after 256; `a_count_o` stays 0.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and default parameters for the 1:2 stream demultiplexer.
// Channel A is index 0 and channel B is index 1 in every per-channel array.
package stream_demux_pkg;

  typedef enum logic {CH_A = 1'b0, CH_B = 1'b1} ch_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 2;
  localparam int DEF_CNT_W  = 8;
  localparam int NUM_CH     = 2;

endpackage

// File: rtl/stream_fifo.sv
// Single-clock synchronous FIFO with a combinational head (first-word fall-through).
// Pushes into a full FIFO and pops from an empty one are ignored.
module stream_fifo
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_occ;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_occ == FULL_CNT);
  assign valid_o = (r_occ != '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && valid_o;

  // Head is forced to zero while empty so the output is defined after reset
  // without having to clear the storage array.
  assign data_o = valid_o ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + ONE_CNT;
        2'b01:   r_occ <= r_occ - ONE_CNT;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/stream_demux2.sv
// 1:2 stream demultiplexer: steers each accepted beat into a per-channel FIFO
// so that a stalled consumer never blocks the other channel.
module stream_demux2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              sel_i,
  output logic              a_valid_o,
  input  logic              a_ready_i,
  output logic [DATA_W-1:0] a_data_o,
  output logic [CNT_W-1:0]  a_count_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  output logic [DATA_W-1:0] b_data_o,
  output logic [CNT_W-1:0]  b_count_o
);

  ch_e               w_sel;
  logic              w_accept;
  logic [NUM_CH-1:0] w_sel_onehot;
  logic [NUM_CH-1:0] w_ch_ready;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_valid;
  logic [DATA_W-1:0] w_data  [NUM_CH];
  logic [CNT_W-1:0]  r_count [NUM_CH];

  assign w_sel        = ch_e'(sel_i);
  assign w_sel_onehot = {(w_sel == CH_B), (w_sel == CH_A)};
  assign w_ch_ready   = {b_ready_i, a_ready_i};

  // Ready looks only at the registered full flag of the selected channel;
  // a pop in the same cycle does not make room for a push.
  assign in_ready_o = reset_n && !((w_sel == CH_B) ? w_full[1] : w_full[0]);
  assign w_accept   = in_valid_i && in_ready_o;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_push[gi] = w_accept && w_sel_onehot[gi];
    assign w_pop[gi]  = w_valid[gi] && w_ch_ready[gi];

    stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (w_push[gi]),
      .data_i  (in_data_i),
      .full_o  (w_full[gi]),
      .pop_i   (w_pop[gi]),
      .valid_o (w_valid[gi]),
      .data_o  (w_data[gi])
    );

    always_ff @(posedge clk) begin
      if (!reset_n)        r_count[gi] <= '0;
      else if (w_pop[gi])  r_count[gi] <= r_count[gi] + 1'b1;
    end
  end

  assign a_valid_o = w_valid[0];
  assign a_data_o  = w_data[0];
  assign a_count_o = r_count[0];
  assign b_valid_o = w_valid[1];
  assign b_data_o  = w_data[1];
  assign b_count_o = r_count[1];

endmodule

// File: tb/tb_stream_demux2.sv
// Directed self-checking bench for stream_demux2 with hand-computed expectations.
// Inputs change 1 ns after each rising edge; outputs are checked 1 ns later.
`timescale 1ns/1ps
module tb_stream_demux2;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              sel_i;
  logic              a_valid_o, b_valid_o;
  logic              a_ready_i, b_ready_i;
  logic [DATA_W-1:0] a_data_o, b_data_o;
  logic [CNT_W-1:0]  a_count_o, b_count_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  stream_demux2 #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .sel_i      (sel_i),
    .a_valid_o  (a_valid_o),
    .a_ready_i  (a_ready_i),
    .a_data_o   (a_data_o),
    .a_count_o  (a_count_o),
    .b_valid_o  (b_valid_o),
    .b_ready_i  (b_ready_i),
    .b_data_o   (b_data_o),
    .b_count_o  (b_count_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; new inputs are applied here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    in_valid_i = v;
    sel_i      = s;
    in_data_i  = d;
  endtask

  initial begin
    reset_n = 1'b0; a_ready_i = 1'b0; b_ready_i = 1'b0;
    drive(1'b0, 1'b0, 8'h00);

    // ---------------- power-on reset ----------------
    repeat (3) step();
    drive(1'b1, 1'b0, 8'h55); settle();
    check_eq("por_in_ready", in_ready_o, 0);
    check_eq("por_a_valid",  a_valid_o, 0);
    check_eq("por_b_valid",  b_valid_o, 0);
    check_eq("por_a_data",   a_data_o, 0);
    check_eq("por_b_data",   b_data_o, 0);
    check_eq("por_a_count",  a_count_o, 0);
    check_eq("por_b_count",  b_count_o, 0);
    drive(1'b0, 1'b0, 8'h00);

    // ---------------- reset mid-stream ----------------
    reset_n = 1'b1; settle();
    check_eq("rel_ready_sel0", in_ready_o, 1);
    sel_i = 1'b1; settle();
    check_eq("rel_ready_sel1", in_ready_o, 1);
    drive(1'b1, 1'b0, 8'h11); settle();
    check_eq("mr_ready_11", in_ready_o, 1);
    step();
    check_eq("mr_a_valid_lat", a_valid_o, 1);
    check_eq("mr_a_data_lat",  a_data_o, 8'h11);
    drive(1'b1, 1'b0, 8'h22); settle();
    check_eq("mr_ready_22", in_ready_o, 1);
    step();
    check_eq("mr_a_full_ready", in_ready_o, 0);
    drive(1'b0, 1'b0, 8'h00);
    reset_n = 1'b0; settle();
    check_eq("mr_ready_in_rst", in_ready_o, 0);
    step();
    check_eq("mr_ready_in_rst2", in_ready_o, 0);
    step();
    check_eq("mr_a_valid_rst", a_valid_o, 0);
    check_eq("mr_a_data_rst",  a_data_o, 0);
    check_eq("mr_a_count_rst", a_count_o, 0);
    check_eq("mr_b_count_rst", b_count_o, 0);
    reset_n = 1'b1; a_ready_i = 1'b1; settle();
    check_eq("mr_a_valid_post", a_valid_o, 0);
    step();
    check_eq("mr_a_valid_post2", a_valid_o, 0);
    check_eq("mr_a_count_post",  a_count_o, 0);

    // ---------------- basic steering ----------------
    b_ready_i = 1'b1;
    drive(1'b1, 1'b0, 8'h11); settle();
    check_eq("bs_ready_11", in_ready_o, 1);
    step();
    check_eq("bs_a_valid_11", a_valid_o, 1);
    check_eq("bs_a_data_11",  a_data_o, 8'h11);
    check_eq("bs_b_valid_0",  b_valid_o, 0);
    drive(1'b1, 1'b1, 8'hB2); settle();
    check_eq("bs_ready_b2", in_ready_o, 1);
    step();
    check_eq("bs_a_valid_gone", a_valid_o, 0);
    check_eq("bs_b_valid_b2",   b_valid_o, 1);
    check_eq("bs_b_data_b2",    b_data_o, 8'hB2);
    check_eq("bs_a_count_1",    a_count_o, 1);
    drive(1'b1, 1'b0, 8'h33); settle();
    step();
    check_eq("bs_a_data_33",  a_data_o, 8'h33);
    check_eq("bs_a_valid_33", a_valid_o, 1);
    check_eq("bs_b_count_1",  b_count_o, 1);
    drive(1'b0, 1'b0, 8'h00);
    step();
    check_eq("bs_a_count_2", a_count_o, 2);
    check_eq("bs_b_count_f", b_count_o, 1);
    check_eq("bs_a_empty",   a_valid_o, 0);

    // ---------------- backpressure isolation ----------------
    a_ready_i = 1'b0;
    drive(1'b1, 1'b0, 8'h01); settle();
    check_eq("bp_ready_01", in_ready_o, 1);
    step();
    drive(1'b1, 1'b0, 8'h02); settle();
    check_eq("bp_ready_02", in_ready_o, 1);
    step();
    drive(1'b1, 1'b0, 8'h03); settle();
    check_eq("bp_ready_03", in_ready_o, 0);
    check_eq("bp_a_head",   a_data_o, 8'h01);
    step();
    drive(1'b1, 1'b1, 8'hB0); settle();
    check_eq("bp_ready_b0", in_ready_o, 1);
    step();
    drive(1'b0, 1'b0, 8'h00); settle();
    check_eq("bp_b_valid",   b_valid_o, 1);
    check_eq("bp_b_data",    b_data_o, 8'hB0);
    check_eq("bp_a_stalled", a_data_o, 8'h01);
    step();
    check_eq("bp_b_count", b_count_o, 2);
    check_eq("bp_a_hold",  a_data_o, 8'h01);
    check_eq("bp_a_count", a_count_o, 2);

    // ---------------- full, no bypass ----------------
    a_ready_i = 1'b1;
    drive(1'b1, 1'b0, 8'h03); settle();
    check_eq("fb_ready_full", in_ready_o, 0);
    step();
    check_eq("fb_a_data_02",  a_data_o, 8'h02);
    check_eq("fb_ready_next", in_ready_o, 1);
    step();
    drive(1'b0, 1'b0, 8'h00); settle();
    check_eq("fb_a_data_03",  a_data_o, 8'h03);
    check_eq("fb_a_valid_03", a_valid_o, 1);
    step();
    check_eq("fb_a_empty", a_valid_o, 0);
    check_eq("fb_a_count", a_count_o, 5);

    // ---------------- simultaneous push/pop ----------------
    a_ready_i = 1'b0;
    drive(1'b1, 1'b0, 8'h40);
    step();
    a_ready_i = 1'b1;
    drive(1'b1, 1'b0, 8'h41); settle();
    check_eq("sp_head_40", a_data_o, 8'h40);
    step();
    a_ready_i = 1'b0;
    drive(1'b0, 1'b0, 8'h00); settle();
    check_eq("sp_a_valid", a_valid_o, 1);
    check_eq("sp_head_41", a_data_o, 8'h41);
    a_ready_i = 1'b1;
    step();
    check_eq("sp_occ_was_1", a_valid_o, 0);
    check_eq("sp_a_count",   a_count_o, 7);

    // ---------------- counter wrap on B ----------------
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    for (int c = 0; c < 256; c++) begin
      drive(1'b1, 1'b1, 8'(c)); settle();
      if (c == 0 || c == 128 || c == 255) check_eq("cw_ready", in_ready_o, 1);
      if (c > 0 && (c % 64) == 1) begin
        check_eq("cw_b_data",  b_data_o, 32'(c - 1));
        check_eq("cw_b_count", b_count_o, 32'(c - 1));
      end
      step();
    end
    drive(1'b0, 1'b0, 8'h00); settle();
    check_eq("cw_b_data_ff", b_data_o, 8'hFF);
    check_eq("cw_count_255", b_count_o, 8'hFF);
    step();
    check_eq("cw_count_wrap", b_count_o, 8'h00);
    check_eq("cw_b_empty",    b_valid_o, 0);
    check_eq("cw_a_count_0",  a_count_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
